// File: rtl/control_seq_pkg.sv
// rtl/control_seq_pkg.sv - shared types for the accumulator CPU instruction sequencer
//
// Purpose: opcode and sequencer-state encodings shared by control_seq and its bench.
// Ports: none (package).
package control_seq_pkg;

  // Sequencer states per instruction; the top checks its parameter against this.
  localparam int STATE_COUNT = 8;

  // Opcode encoding held in the instruction register.
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // One state per clock; the encoding order is the execution order.
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  // Instructions whose result is written into the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/control_seq.sv
// rtl/control_seq.sv - 8-state instruction sequencer issuing all datapath strobes
//
// Purpose: steps INST_ADDR..STORE once per instruction and decodes the memory,
//          IR, PC and accumulator strobes from the registered state plus the
//          current opcode and zero flag. HLT parks the sequencer at OP_ADDR.
// Ports:
//   clk      in   system clock, state advances on posedge
//   rst      in   synchronous active-high reset
//   opcode   in   opcode from the instruction register
//   zero     in   accumulator-is-zero flag (used only in ALU_OP)
//   mem_rd   out  memory read enable
//   load_ir  out  instruction register load
//   halt     out  processor halted
//   inc_pc   out  program counter increment
//   load_ac  out  accumulator load from ALU output
//   load_pc  out  program counter load (jump)
//   mem_wr   out  memory write enable
//   state    out  current sequencer state
module control_seq
  import control_seq_pkg::*;
#(
  parameter int NUM_STATES = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    halt,
  output logic    inc_pc,
  output logic    load_ac,
  output logic    load_pc,
  output logic    mem_wr,
  output state_t  state
);

  // The state encoding and wrap-around rely on exactly eight states.
  if (NUM_STATES != STATE_COUNT) begin : g_bad_num_states
    $error("control_seq: NUM_STATES must be 8");
  end

  state_t state_q, state_d;
  logic   halted_q, halted_d;
  logic   aluop;
  logic   halt_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // A HLT seen in OP_ADDR latches the halted flag; from then on the sequencer
  // stays in OP_ADDR regardless of what the IR holds.
  always_comb begin
    halt_now = halted_q || ((state_q == OP_ADDR) && (opcode == HLT));
    halted_d = halt_now;
    state_d  = halt_now ? OP_ADDR : state_t'(state_q + 3'd1);
  end

  assign aluop = is_aluop(opcode);

  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    unique case (state_q)
      INST_ADDR: ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        // Halted parking suppresses the operand-address PC step.
        if (halted_q || (opcode == HLT)) halt = 1'b1;
        else inc_pc = 1'b1;
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == SKZ) && zero;  // skip the next instruction
        load_pc = (opcode == JMP);
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == JMP);
        load_pc = (opcode == JMP);
        mem_wr  = (opcode == STO);
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - self-checking bench for control_seq
//
// Purpose: drives opcode/zero/rst cycle by cycle, queues expected strobes and
//          state from a reference model, and compares them against the DUT.
// Ports: none (top-level bench).
module tb_control_seq;
  import control_seq_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  opcode_t opcode;
  logic    zero;
  logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  state_t  state;

  always #5 clk = ~clk;

  control_seq #(.NUM_STATES(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .state(state)
  );

  int compared = 0;
  int mismatched = 0;

  // Strobe vector order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  logic [6:0] exp_q[$];
  logic [2:0] est_q[$];
  logic [2:0] m_state;
  logic       m_halted;
  logic [6:0] obs_strb, e_strb;
  logic [2:0] obs_state, e_st;
  logic       obs_inv;
  logic [7:0] rd_m, ir_m, inc_m, ac_m, pc_m, wr_m;
  int         inc_cnt;

  function automatic logic [6:0] model_strb(logic [2:0] st, opcode_t op, logic z, logic h);
    logic alu;
    logic [6:0] v;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    v = 7'b0;
    if (h) return 7'b0010000;
    case (st)
      3'd1:       v = 7'b1000000;
      3'd2, 3'd3: v = 7'b1100000;
      3'd4:       v = (op == HLT) ? 7'b0010000 : 7'b0001000;
      3'd5:       v = {alu, 6'b0};
      3'd6:       v = {alu, 2'b00, (op == SKZ) && z, alu, op == JMP, 1'b0};
      3'd7:       v = {alu, 2'b00, op == JMP, alu, op == JMP, op == STO};
      default:    v = 7'b0;
    endcase
    return v;
  endfunction

  task automatic clear_masks();
    rd_m = '0; ir_m = '0; inc_m = '0; ac_m = '0; pc_m = '0; wr_m = '0; inc_cnt = 0;
  endtask

  // One clock: drive inputs, sample mid-cycle, queue model expectation, advance model.
  task automatic do_cycle(input opcode_t op, input logic z, input logic r);
    opcode = op; zero = z; rst = r;
    @(negedge clk);
    obs_strb  = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
    obs_state = state;
    obs_inv   = !(mem_rd && mem_wr) && (!load_pc || (opcode == JMP)) && !$isunknown(state);
    exp_q.push_back(model_strb(m_state, op, z, m_halted));
    est_q.push_back(m_state);
    if (!$isunknown(obs_state)) begin
      rd_m[obs_state]  |= mem_rd;  ir_m[obs_state] |= load_ir; inc_m[obs_state] |= inc_pc;
      ac_m[obs_state]  |= load_ac; pc_m[obs_state] |= load_pc; wr_m[obs_state]  |= mem_wr;
    end
    inc_cnt += int'(inc_pc);
    @(posedge clk); #1;
    if (r) begin
      m_state = 3'd0; m_halted = 1'b0;
    end else if (m_halted || (m_state == 3'd4 && op == HLT)) begin
      m_state = 3'd4; m_halted = 1'b1;
    end else begin
      m_state = m_state + 3'd1;
    end
  endtask

  task automatic test_reset();
    do_cycle(ADD, 1'b0, 1'b0);
    void'(exp_q.pop_front()); void'(est_q.pop_front());
    compared += 2;
    if (obs_state !== 3'd0) begin mismatched++; $display("FAIL reset_state got=%0d want=0", obs_state); end
    if (obs_strb !== 7'b0) begin mismatched++; $display("FAIL reset_strobes got=%b want=0000000", obs_strb); end
    for (int c = 1; c < 8; c++) do_cycle(ADD, 1'b0, 1'b0);
    exp_q.delete(); est_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 7; c++) begin
      do_cycle(ADD, 1'b0, (c == 5));
      e_strb = exp_q.pop_front(); e_st = est_q.pop_front();
      compared += 2;
      if (obs_strb !== e_strb) begin mismatched++; $display("FAIL rstmid_strobes cyc=%0d got=%b want=%b", c, obs_strb, e_strb); end
      if (obs_state !== e_st) begin mismatched++; $display("FAIL rstmid_state cyc=%0d got=%0d want=%0d", c, obs_state, e_st); end
    end
    // Cycle 5 was OP_FETCH with rst high; cycle 6 must be INST_ADDR, quiet.
    compared += 2;
    if (obs_state !== 3'd0) begin mismatched++; $display("FAIL rstmid_inst_addr got=%0d want=0", obs_state); end
    if (obs_strb !== 7'b0) begin mismatched++; $display("FAIL rstmid_quiet got=%b want=0000000", obs_strb); end
    for (int c = 0; c < 7; c++) do_cycle(ADD, 1'b0, 1'b0);
    exp_q.delete(); est_q.delete();
  endtask

  task automatic test_opcode(input opcode_t op, input logic z, input string nm,
                             input logic [7:0] w_rd, input logic [7:0] w_ir, input logic [7:0] w_inc,
                             input logic [7:0] w_ac, input logic [7:0] w_pc, input logic [7:0] w_wr,
                             input int w_cnt);
    clear_masks();
    for (int c = 0; c < 8; c++) begin
      do_cycle(op, z, 1'b0);
      e_strb = exp_q.pop_front(); e_st = est_q.pop_front();
      compared += 3;
      if (obs_strb !== e_strb) begin mismatched++; $display("FAIL %s_strobes cyc=%0d got=%b want=%b", nm, c, obs_strb, e_strb); end
      if (obs_state !== e_st) begin mismatched++; $display("FAIL %s_state cyc=%0d got=%0d want=%0d", nm, c, obs_state, e_st); end
      if (obs_inv !== 1'b1) begin mismatched++; $display("FAIL %s_invariant cyc=%0d got=%b want=1", nm, c, obs_inv); end
    end
    compared += 7;
    if (rd_m !== w_rd) begin mismatched++; $display("FAIL %s_mem_rd_states got=%b want=%b", nm, rd_m, w_rd); end
    if (ir_m !== w_ir) begin mismatched++; $display("FAIL %s_load_ir_states got=%b want=%b", nm, ir_m, w_ir); end
    if (inc_m !== w_inc) begin mismatched++; $display("FAIL %s_inc_pc_states got=%b want=%b", nm, inc_m, w_inc); end
    if (ac_m !== w_ac) begin mismatched++; $display("FAIL %s_load_ac_states got=%b want=%b", nm, ac_m, w_ac); end
    if (pc_m !== w_pc) begin mismatched++; $display("FAIL %s_load_pc_states got=%b want=%b", nm, pc_m, w_pc); end
    if (wr_m !== w_wr) begin mismatched++; $display("FAIL %s_mem_wr_states got=%b want=%b", nm, wr_m, w_wr); end
    if (inc_cnt !== w_cnt) begin mismatched++; $display("FAIL %s_inc_pulses got=%0d want=%0d", nm, inc_cnt, w_cnt); end
    compared++;
    if (state !== INST_ADDR) begin mismatched++; $display("FAIL %s_wrap got=%0d want=0", nm, state); end
  endtask

  // zero is high everywhere except ALU_OP, so it must not cause a skip.
  task automatic test_skz_zero_elsewhere();
    clear_masks();
    for (int c = 0; c < 8; c++) begin
      do_cycle(SKZ, (c != 6), 1'b0);
      e_strb = exp_q.pop_front(); e_st = est_q.pop_front();
      compared += 2;
      if (obs_strb !== e_strb) begin mismatched++; $display("FAIL skzmix_strobes cyc=%0d got=%b want=%b", c, obs_strb, e_strb); end
      if (obs_state !== e_st) begin mismatched++; $display("FAIL skzmix_state cyc=%0d got=%0d want=%0d", c, obs_state, e_st); end
    end
    compared++;
    if (inc_cnt !== 1) begin mismatched++; $display("FAIL skzmix_inc_pulses got=%0d want=1", inc_cnt); end
  endtask

  task automatic test_hlt();
    for (int c = 0; c < 20; c++) begin
      do_cycle((c < 12) ? HLT : ADD, 1'($urandom_range(0, 1)), 1'b0);
      e_strb = exp_q.pop_front(); e_st = est_q.pop_front();
      compared += 2;
      if (obs_strb !== e_strb) begin mismatched++; $display("FAIL hlt_strobes cyc=%0d got=%b want=%b", c, obs_strb, e_strb); end
      if (obs_state !== e_st) begin mismatched++; $display("FAIL hlt_state cyc=%0d got=%0d want=%0d", c, obs_state, e_st); end
      if (c >= 4) begin
        compared += 3;
        if (obs_state !== 3'd4) begin mismatched++; $display("FAIL hlt_stuck cyc=%0d got=%0d want=4", c, obs_state); end
        if (obs_strb[4] !== 1'b1) begin mismatched++; $display("FAIL hlt_halt cyc=%0d got=%b want=1", c, obs_strb[4]); end
        if (obs_strb[3] !== 1'b0) begin mismatched++; $display("FAIL hlt_no_inc cyc=%0d got=%b want=0", c, obs_strb[3]); end
      end
    end
    do_cycle(ADD, 1'b0, 1'b1);
    void'(exp_q.pop_front()); void'(est_q.pop_front());
    for (int c = 0; c < 8; c++) begin
      do_cycle(ADD, 1'b0, 1'b0);
      e_strb = exp_q.pop_front(); e_st = est_q.pop_front();
      compared += 2;
      if (obs_strb !== e_strb) begin mismatched++; $display("FAIL hlt_resume_strobes cyc=%0d got=%b want=%b", c, obs_strb, e_strb); end
      if (obs_state !== 3'(c)) begin mismatched++; $display("FAIL hlt_resume_state cyc=%0d got=%0d want=%0d", c, obs_state, c); end
    end
  endtask

  task automatic test_back_to_back();
    opcode_t op;
    for (int i = 0; i < 6; i++) begin
      op = opcode_t'($urandom_range(1, 7));
      for (int c = 0; c < 8; c++) begin
        do_cycle(op, 1'($urandom_range(0, 1)), 1'b0);
        e_strb = exp_q.pop_front(); e_st = est_q.pop_front();
        compared += 3;
        if (obs_strb !== e_strb) begin mismatched++; $display("FAIL b2b_strobes op=%0d cyc=%0d got=%b want=%b", op, c, obs_strb, e_strb); end
        if (obs_state !== e_st) begin mismatched++; $display("FAIL b2b_state op=%0d cyc=%0d got=%0d want=%0d", op, c, obs_state, e_st); end
        if (obs_inv !== 1'b1) begin mismatched++; $display("FAIL b2b_invariant op=%0d cyc=%0d got=%b want=1", op, c, obs_inv); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; opcode = ADD; zero = 1'b0;
    m_state = 3'd0; m_halted = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_reset_mid();
    //                         mem_rd        load_ir       inc_pc        load_ac       load_pc       mem_wr     pulses
    test_opcode(ADD, 1'b0, "add",    8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'b00000000, 8'b0, 1);
    test_opcode(SKZ, 1'b1, "skz_z1", 8'b00001110, 8'b00001100, 8'b01010000, 8'b00000000, 8'b00000000, 8'b0, 2);
    test_opcode(SKZ, 1'b0, "skz_z0", 8'b00001110, 8'b00001100, 8'b00010000, 8'b00000000, 8'b00000000, 8'b0, 1);
    test_opcode(JMP, 1'b0, "jmp",    8'b00001110, 8'b00001100, 8'b10010000, 8'b00000000, 8'b11000000, 8'b0, 2);
    test_opcode(STO, 1'b1, "sto",    8'b00001110, 8'b00001100, 8'b00010000, 8'b00000000, 8'b00000000, 8'b10000000, 1);
    test_opcode(LDA, 1'b1, "lda",    8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'b00000000, 8'b0, 1);
    test_skz_zero_elsewhere();
    test_back_to_back();
    test_hlt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
